// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipe: per-latch commands, PC enable,
// halt-drain sequencing and saturating stall/flush performance counters.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {
    PIPE_UPDATE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_FLUSH  = 2'd2
  } pipe_state_t;
endpackage

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req,
  input  logic             redirect_mem,
  input  logic             halt_mem,
  input  logic             load_ex,
  input  logic [4:0]       regWSEL_ex,
  input  logic [4:0]       rs_dec,
  input  logic [4:0]       rt_dec,
  input  logic             uses_rt_dec,
  output pipe_state_t      fd_state,
  output pipe_state_t      de_state,
  output pipe_state_t      em_state,
  output pipe_state_t      mw_state,
  output logic             pc_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } ctrl_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_state_t state, state_nxt;
  logic        load_use;
  logic        stall_inc;
  logic        flush_inc;

  // A load writing r0 never creates a dependency.
  assign load_use = load_ex && (regWSEL_ex != 5'd0) &&
                    ((regWSEL_ex == rs_dec) || (uses_rt_dec && (regWSEL_ex == rt_dec)));

  assign halted = (state == S_HALTED);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_RUN;
    else     state <= state_nxt;
  end

  // Priority arbitration; a pending memory wait masks every lower decision.
  always_comb begin
    state_nxt = state;
    fd_state  = PIPE_UPDATE;
    de_state  = PIPE_UPDATE;
    em_state  = PIPE_UPDATE;
    mw_state  = PIPE_UPDATE;
    pc_en     = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state)
      S_RUN: begin
        if (dmem_req && !dhit) begin
          fd_state = PIPE_STALL;
          de_state = PIPE_STALL;
          em_state = PIPE_STALL;
          mw_state = PIPE_FLUSH;
        end else if (halt_mem) begin
          fd_state  = PIPE_FLUSH;
          de_state  = PIPE_FLUSH;
          em_state  = PIPE_FLUSH;
          state_nxt = S_DRAIN;
        end else if (redirect_mem) begin
          fd_state  = PIPE_FLUSH;
          de_state  = PIPE_FLUSH;
          em_state  = PIPE_FLUSH;
          pc_en     = 1'b1;
          flush_inc = 1'b1;
        end else if (load_use) begin
          fd_state = PIPE_STALL;
          de_state = PIPE_FLUSH;
        end else if (!ihit) begin
          fd_state = PIPE_FLUSH;
        end else begin
          pc_en = 1'b1;
        end
        stall_inc = !pc_en;
      end
      S_DRAIN: begin
        fd_state  = PIPE_FLUSH;
        de_state  = PIPE_FLUSH;
        em_state  = PIPE_FLUSH;
        mw_state  = PIPE_STALL;
        state_nxt = S_HALTED;
      end
      S_HALTED: begin
        fd_state = PIPE_STALL;
        de_state = PIPE_STALL;
        em_state = PIPE_STALL;
        mw_state = PIPE_STALL;
      end
      default: begin
        fd_state  = PIPE_FLUSH;
        de_state  = PIPE_FLUSH;
        em_state  = PIPE_FLUSH;
        mw_state  = PIPE_FLUSH;
        state_nxt = S_RUN;
      end
    endcase
    // Reset forces bubbles into every latch regardless of the inputs.
    if (RST) begin
      fd_state  = PIPE_FLUSH;
      de_state  = PIPE_FLUSH;
      em_state  = PIPE_FLUSH;
      mw_state  = PIPE_FLUSH;
      pc_en     = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      state_nxt = S_RUN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_inc && (stall_cycles != CNT_MAX)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_events != CNT_MAX)) flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl; narrow counters make saturation reachable.
module tb_pipeline_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam logic [7:0] ALL_U  = {PIPE_UPDATE, PIPE_UPDATE, PIPE_UPDATE, PIPE_UPDATE};
  localparam logic [7:0] ALL_S  = {PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL};
  localparam logic [7:0] ALL_F  = {PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH};
  localparam logic [7:0] MEMW   = {PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_FLUSH};
  localparam logic [7:0] SQUASH = {PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, PIPE_UPDATE};
  localparam logic [7:0] DRAIN  = {PIPE_FLUSH, PIPE_FLUSH, PIPE_FLUSH, PIPE_STALL};
  localparam logic [7:0] LDUSE  = {PIPE_STALL, PIPE_FLUSH, PIPE_UPDATE, PIPE_UPDATE};
  localparam logic [7:0] FMISS  = {PIPE_FLUSH, PIPE_UPDATE, PIPE_UPDATE, PIPE_UPDATE};

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             ihit = 1'b1, dhit = 1'b0, dmem_req = 1'b0;
  logic             redirect_mem = 1'b0, halt_mem = 1'b0, load_ex = 1'b0;
  logic [4:0]       regWSEL_ex = '0, rs_dec = '0, rt_dec = '0;
  logic             uses_rt_dec = 1'b0;
  pipe_state_t      fd_state, de_state, em_state, mw_state;
  logic             pc_en, halted;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [7:0]       lat;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .redirect_mem(redirect_mem), .halt_mem(halt_mem), .load_ex(load_ex),
    .regWSEL_ex(regWSEL_ex), .rs_dec(rs_dec), .rt_dec(rt_dec), .uses_rt_dec(uses_rt_dec),
    .fd_state(fd_state), .de_state(de_state), .em_state(em_state), .mw_state(mw_state),
    .pc_en(pc_en), .halted(halted), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 CLK = ~CLK;
  assign lat = {fd_state, de_state, em_state, mw_state};

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; redirect_mem = 1'b0; halt_mem = 1'b0;
    load_ex = 1'b0; regWSEL_ex = '0; rs_dec = '0; rt_dec = '0; uses_rt_dec = 1'b0;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    tick();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    tick();
    idle_inputs();
    RST = 1'b1;
    #1;
    checks++; if (lat !== ALL_F) begin errors++; $display("FAIL reset_latches got %h exp %h", lat, ALL_F); end
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL reset_pc_en got %b exp 0", pc_en); end
    checks++; if (stall_cycles !== '0 || flush_events !== '0) begin errors++;
      $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cycles, flush_events); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    RST = 1'b0;
    #1;
    checks++; if (lat !== ALL_U || pc_en !== 1'b1) begin errors++;
      $display("FAIL post_reset_run got %h/%b exp %h/1", lat, pc_en, ALL_U); end
  endtask

  task automatic test_load_use();
    pulse_reset();
    idle_inputs();
    load_ex = 1'b1; regWSEL_ex = 5'd5; rs_dec = 5'd5;
    #1;
    checks++; if (lat !== LDUSE || pc_en !== 1'b0) begin errors++;
      $display("FAIL load_use_rs got %h/%b exp %h/0", lat, pc_en, LDUSE); end
    tick();
    idle_inputs();
    #1;
    checks++; if (lat !== ALL_U || pc_en !== 1'b1) begin errors++;
      $display("FAIL load_use_one_cycle got %h/%b exp %h/1", lat, pc_en, ALL_U); end
    checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL load_use_count got %0d exp 1", stall_cycles); end
    load_ex = 1'b1; regWSEL_ex = 5'd0; rs_dec = 5'd0;
    #1;
    checks++; if (lat !== ALL_U || pc_en !== 1'b1) begin errors++;
      $display("FAIL load_use_r0 got %h/%b exp %h/1", lat, pc_en, ALL_U); end
    regWSEL_ex = 5'd7; rs_dec = 5'd3; rt_dec = 5'd7; uses_rt_dec = 1'b1;
    #1;
    checks++; if (lat !== LDUSE || pc_en !== 1'b0) begin errors++;
      $display("FAIL load_use_rt got %h/%b exp %h/0", lat, pc_en, LDUSE); end
    uses_rt_dec = 1'b0;
    #1;
    checks++; if (lat !== ALL_U || pc_en !== 1'b1) begin errors++;
      $display("FAIL load_use_rt_unused got %h/%b exp %h/1", lat, pc_en, ALL_U); end
    tick();
    checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL no_hazard_count got %0d exp 1", stall_cycles); end
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    pulse_reset();
    idle_inputs();
    dmem_req = 1'b1; redirect_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (lat !== MEMW || pc_en !== 1'b0) begin errors++;
        $display("FAIL mem_wait_cyc%0d got %h/%b exp %h/0", i, lat, pc_en, MEMW); end
      tick();
    end
    dhit = 1'b1;
    #1;
    checks++; if (lat !== SQUASH || pc_en !== 1'b1) begin errors++;
      $display("FAIL mem_wait_release got %h/%b exp %h/1", lat, pc_en, SQUASH); end
    tick();
    idle_inputs();
    checks++; if (flush_events !== 4'd1 || stall_cycles !== 4'd3) begin errors++;
      $display("FAIL mem_wait_counters got %0d/%0d exp 1/3", flush_events, stall_cycles); end
  endtask

  task automatic test_redirect_vs_load_use();
    pulse_reset();
    idle_inputs();
    redirect_mem = 1'b1; load_ex = 1'b1; regWSEL_ex = 5'd5; rs_dec = 5'd5;
    #1;
    checks++; if (lat !== SQUASH || pc_en !== 1'b1) begin errors++;
      $display("FAIL redirect_wins got %h/%b exp %h/1", lat, pc_en, SQUASH); end
    tick();
    idle_inputs();
    checks++; if (flush_events !== 4'd1 || stall_cycles !== 4'd0) begin errors++;
      $display("FAIL redirect_wins_counters got %0d/%0d exp 1/0", flush_events, stall_cycles); end
  endtask

  task automatic test_halt();
    pulse_reset();
    idle_inputs();
    halt_mem = 1'b1;
    #1;
    checks++; if (lat !== SQUASH || pc_en !== 1'b0 || halted !== 1'b0) begin errors++;
      $display("FAIL halt_cyc0 got %h/%b/%b exp %h/0/0", lat, pc_en, halted, SQUASH); end
    tick();
    halt_mem = 1'b0;
    #1;
    checks++; if (lat !== DRAIN || pc_en !== 1'b0 || halted !== 1'b0) begin errors++;
      $display("FAIL halt_drain got %h/%b/%b exp %h/0/0", lat, pc_en, halted, DRAIN); end
    tick();
    for (int i = 0; i < 4; i++) begin
      redirect_mem = i[0]; ihit = i[1]; load_ex = 1'b1; regWSEL_ex = 5'd2; rs_dec = 5'd2;
      #1;
      checks++; if (lat !== ALL_S || pc_en !== 1'b0 || halted !== 1'b1) begin errors++;
        $display("FAIL halted_cyc%0d got %h/%b/%b exp %h/0/1", i, lat, pc_en, halted, ALL_S); end
      tick();
    end
    checks++; if (stall_cycles !== 4'd1 || flush_events !== 4'd0) begin errors++;
      $display("FAIL halted_counters got %0d/%0d exp 1/0", stall_cycles, flush_events); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (halted !== 1'b0 || lat !== ALL_F) begin errors++;
      $display("FAIL halted_async_reset got %b/%h exp 0/%h", halted, lat, ALL_F); end
    RST = 1'b0;
    idle_inputs();
    #1;
    checks++; if (lat !== ALL_U || pc_en !== 1'b1) begin errors++;
      $display("FAIL rerun_after_halt got %h/%b exp %h/1", lat, pc_en, ALL_U); end
  endtask

  task automatic test_saturation();
    pulse_reset();
    idle_inputs();
    ihit = 1'b0;
    #1;
    checks++; if (lat !== FMISS || pc_en !== 1'b0) begin errors++;
      $display("FAIL fetch_miss got %h/%b exp %h/0", lat, pc_en, FMISS); end
    for (int i = 0; i < 15; i++) tick();
    checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL stall_reach_max got %0d exp 15", stall_cycles); end
    for (int i = 0; i < 4; i++) tick();
    checks++; if (stall_cycles !== 4'd15) begin errors++; $display("FAIL stall_saturate got %0d exp 15", stall_cycles); end
    ihit = 1'b1; redirect_mem = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    checks++; if (flush_events !== 4'd15 || stall_cycles !== 4'd15) begin errors++;
      $display("FAIL flush_saturate got %0d/%0d exp 15/15", flush_events, stall_cycles); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect_vs_load_use();
    test_halt();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller that drives the per-latch state inputs (`fd_state`, `de_state`, `em_state`, `mw_state`) of the four pipeline latches, plus the PC enable. It arbitrates memory wait states, taken-branch/jump redirects resolved in MEM, load-use hazards and instruction-fetch misses. It also runs a halt-drain state machine that retires the halt instruction through WB and then freezes the pipe. Two saturating performance counters (stall cycles, flush events) are exposed to the system.

## Interface

Parameters:
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `CLK`  in  1  system clock; all state updates on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `ihit`  in  1  instruction fetch completes this cycle.
- `dhit`  in  1  data access completes this cycle.
- `dmem_req`  in  1  MEM stage holds a load or store (`dREN_mem | dWEN_mem`).
- `redirect_mem`  in  1  taken branch or jump resolved in MEM stage.
- `halt_mem`  in  1  halt instruction in MEM stage.
- `load_ex`  in  1  EX stage holds a load (`dREN_ex`).
- `regWSEL_ex`  in  5  destination register of the EX instruction.
- `rs_dec`  in  5  DEC source register rs.
- `rt_dec`  in  5  DEC source register rt.
- `uses_rt_dec`  in  1  DEC instruction reads rt.
- `fd_state`, `de_state`, `em_state`, `mw_state`  out  pipe_state_t  latch commands: PIPE_UPDATE (capture), PIPE_STALL (hold), PIPE_FLUSH (load bubble).
- `pc_en`  out  1  PC register may update.
- `halted`  out  1  pipeline frozen after halt retired.
- `stall_cycles`  out  CNT_W  count of RUN cycles with `pc_en`=0.
- `flush_events`  out  CNT_W  count of accepted redirects.

## Operation

FSM has three states: RUN, DRAIN, HALTED. Latch commands are combinational from the FSM state and the inputs (Mealy), and take effect at the next edge.

In RUN, the first matching rule applies:
1. **Memory wait** (`dmem_req & ~dhit`): fd/de/em=STALL, mw=FLUSH, `pc_en`=0.
2. **Halt** (`halt_mem`): fd/de/em=FLUSH, mw=UPDATE, `pc_en`=0. Next state is DRAIN.
3. **Redirect** (`redirect_mem`): fd/de/em=FLUSH, mw=UPDATE, `pc_en`=1 (PC loads the target). `flush_events`++.
4. **Load-use** (`load_ex & regWSEL_ex!=0 & (regWSEL_ex==rs_dec | (uses_rt_dec & regWSEL_ex==rt_dec))`): fd=STALL, de=FLUSH, em/mw=UPDATE, `pc_en`=0.
5. **Fetch miss** (`~ihit`): fd=FLUSH, de/em/mw=UPDATE, `pc_en`=0.
6. **Otherwise**: all latches UPDATE, `pc_en`=1.

DRAIN lasts one cycle: fd/de/em=FLUSH, mw=STALL (holds the halt in WB), `pc_en`=0. Next state is HALTED.

HALTED: all latches STALL, `pc_en`=0, `halted`=1. HALTED is sticky until `RST`, and all inputs are ignored.

Counters:
- `stall_cycles` increments in every RUN cycle where `pc_en`=0, including the halt cycle.
- Both counters saturate at all-ones and never wrap.
- Neither counter changes in DRAIN or HALTED.

## Timing

- Reset (asynchronous): state=RUN, both counters 0, `halted`=0. While `RST` is high, all latch outputs are FLUSH and `pc_en`=0, regardless of the other inputs.
- Decision latency is 0 cycles (combinational). Counter and FSM updates take 1 cycle.
- A memory wait holds every decision below it. A redirect or halt arriving with `dmem_req & ~dhit` is honoured only in the cycle `dhit` rises.
- Redirect and load-use in the same cycle: the redirect wins, with no stall, because the DEC instruction is being squashed.
- Load-use with `regWSEL_ex`=0 is not a hazard.
- A load-use stall lasts exactly one cycle: after the edge, the load has moved to MEM and the bubble sits in EX.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately (asynchronous).
- From halt detection, `halted` rises 2 edges later.

## Test plan

- **Reset:** assert `RST` with `ihit`=1. Required: all latch outputs FLUSH, `pc_en`=0, counters 0. After release with `ihit`=1 and no hazards: all UPDATE, `pc_en`=1.
- **Load-use:** `load_ex`=1, `regWSEL_ex`=5, `rs_dec`=5. Required: fd=STALL, de=FLUSH, `pc_en`=0 for one cycle, then `stall_cycles`=1. Repeat with `regWSEL_ex`=0: no stall.
- **Memory wait:** `dmem_req`=1, `dhit`=0 for 3 cycles, with `redirect_mem`=1 throughout. Required: fd/de/em=STALL, mw=FLUSH each cycle. When `dhit`=1, the redirect is taken and `flush_events`=1, `stall_cycles`=3.
- **Redirect beats load-use:** both conditions true in the same cycle. Required: fd/de/em=FLUSH, `pc_en`=1, `flush_events`++, and `stall_cycles` unchanged.
- **Halt:** pulse `halt_mem`. Required: cycle 0 mw=UPDATE with fd/de/em=FLUSH; cycle 1 DRAIN with mw=STALL; from cycle 2 `halted`=1 with all STALL, unaffected by `redirect_mem` or `ihit` toggling.
- **Saturation:** preload `stall_cycles` near max by forcing, then hold `ihit`=0 for 4 cycles. Required: counter stops at `2^CNT_W-1`.
